q_update_pipe: RTL and testbench

//  Q-learning update stage, directly downstream of the state/action/reward delay blocks.

---
 rtl/q_update_pipe.sv | 153 +++++++++++++++
 tb/tb_q_update_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/q_update_pipe.sv
`default_nettype none
// q_update_pipe: 3-stage Q-learning update, Q' = Q + alpha*(r + gamma*maxQ - Q), with RAM write-back
// and in-flight forwarding. Optional macro QUPD_SAT_EN clamps Q' instead of two's-complement wrap.
module q_update_pipe #(
  parameter int DW       = 16,
  parameter int SW       = 6,
  parameter int AW       = 2,
  parameter int ALPHA_SH = 2,
  parameter int GAMMA_SH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [SW-1:0]        state,
  input  logic [AW-1:0]        action,
  input  logic [DW-1:0]        reward,
  input  logic [DW-1:0]        q_cur,
  input  logic [DW-1:0]        q_max,
  output logic                 wr_en,
  output logic [SW+AW-1:0]     wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic                 sat,
  output logic [15:0]          upd_cnt
);

  localparam int XW  = DW + 2;
  localparam int ADW = SW + AW;

  logic            r_s1_valid;
  logic [ADW-1:0]  r_s1_addr;
  logic [DW-1:0]   r_s1_rew;
  logic [DW-1:0]   r_s1_q;
  logic [DW-1:0]   r_s1_gq;

  logic            r_s2_valid;
  logic [ADW-1:0]  r_s2_addr;
  logic [DW-1:0]   r_s2_rew;
  logic [DW-1:0]   r_s2_q;
  logic [DW-1:0]   r_s2_gq;

  logic            r_wr_en;
  logic [ADW-1:0]  r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic            r_sat;
  logic [15:0]     r_upd_cnt;

  // gamma*maxQ computed before S1 so S2 only carries one adder chain
  logic signed [DW-1:0] w_qmax;
  logic signed [DW-1:0] w_gq;
  assign w_qmax = q_max;
  assign w_gq   = w_qmax - (w_qmax >>> GAMMA_SH);

  logic signed [XW-1:0] w_r_x;
  logic signed [XW-1:0] w_gq_x;
  logic signed [XW-1:0] w_q_x;
  logic signed [XW-1:0] w_td;
  logic signed [XW-1:0] w_qn;
  assign w_r_x  = {{2{r_s2_rew[DW-1]}}, r_s2_rew};
  assign w_gq_x = {{2{r_s2_gq[DW-1]}},  r_s2_gq};
  assign w_q_x  = {{2{r_s2_q[DW-1]}},   r_s2_q};
  assign w_td   = w_r_x + w_gq_x - w_q_x;
  assign w_qn   = w_q_x + (w_td >>> ALPHA_SH);

  logic [DW-1:0] w_q_fin;
  logic          w_sat;
`ifdef QUPD_SAT_EN
  logic w_ovf;
  assign w_ovf = ~((&w_qn[XW-1:DW-1]) | ~(|w_qn[XW-1:DW-1]));
  always_comb begin
    w_q_fin = w_qn[DW-1:0];
    w_sat   = 1'b0;
    if (w_ovf) begin
      w_sat   = 1'b1;
      w_q_fin = w_qn[XW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_qn[XW-1:DW];
  assign w_q_fin     = w_qn[DW-1:0];
  assign w_sat       = 1'b0;
`endif

  // Newest in-flight result for the same address wins over the RAM read
  logic [DW-1:0] w_q_fwd;
  always_comb begin
    w_q_fwd = r_s1_q;
    if (r_s2_valid && (r_s2_addr == r_s1_addr)) begin
      w_q_fwd = w_q_fin;
    end else if (r_wr_en && (r_wr_addr == r_s1_addr)) begin
      w_q_fwd = r_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_rew   <= '0;
      r_s1_q     <= '0;
      r_s1_gq    <= '0;
    end else begin
      r_s1_valid <= in_valid & ~flush;
      r_s1_addr  <= {state, action};
      r_s1_rew   <= reward;
      r_s1_q     <= q_cur;
      r_s1_gq    <= w_gq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_rew   <= '0;
      r_s2_q     <= '0;
      r_s2_gq    <= '0;
    end else begin
      r_s2_valid <= r_s1_valid & ~flush;
      r_s2_addr  <= r_s1_addr;
      r_s2_rew   <= r_s1_rew;
      r_s2_q     <= w_q_fwd;
      r_s2_gq    <= r_s1_gq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_sat     <= 1'b0;
      r_upd_cnt <= '0;
    end else begin
      r_wr_en <= r_s2_valid & ~flush;
      if (r_s2_valid && !flush) begin
        r_wr_addr <= r_s2_addr;
        r_wr_data <= w_q_fin;
        r_sat     <= w_sat;
        r_upd_cnt <= r_upd_cnt + 16'd1;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign sat     = r_sat;
  assign upd_cnt = r_upd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_q_update_pipe.sv
`default_nettype none
// tb_q_update_pipe: directed and randomized checks of q_update_pipe against a cycle-history reference model.
module tb_q_update_pipe;

  localparam int NH = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [5:0]  state;
  logic [1:0]  action;
  logic [15:0] reward;
  logic [15:0] q_cur;
  logic [15:0] q_max;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        sat;
  logic [15:0] upd_cnt;

  q_update_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .state    (state),
    .action   (action),
    .reward   (reward),
    .q_cur    (q_cur),
    .q_max    (q_max),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sat      (sat),
    .upd_cnt  (upd_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // History of every sampled bundle, indexed by edge number
  bit       hv  [NH];
  bit       hf  [NH];
  bit       hw  [NH];
  bit [7:0] ha  [NH];
  int       hr  [NH];
  int       hqc [NH];
  int       hqm [NH];
  int       hres[NH];
  int       cyc  = 0;
  int       base = 0;

  logic        exp_we;
  logic [7:0]  exp_addr;
  logic [15:0] exp_data;
  logic        exp_sat;
  logic [15:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Q' from the update rule with plain integer arithmetic
  function automatic int upd(input int r, input int qm, input int q, output bit sb);
    int gq;
    int td;
    int qn;
    gq = qm - (qm >>> 3);
    td = r + gq - q;
    qn = q + (td >>> 2);
    sb = 1'b0;
`ifdef QUPD_SAT_EN
    if (qn > 32767) begin
      qn = 32767;
      sb = 1'b1;
    end else if (qn < -32768) begin
      qn = -32768;
      sb = 1'b1;
    end
`else
    qn = ((qn + 32768) & 32'hFFFF) - 32768;
`endif
    return qn;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".wr_en"},   32'(wr_en),   32'(exp_we));
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(exp_addr));
    chk({tag, ".wr_data"}, 32'(wr_data), 32'(exp_data));
    chk({tag, ".sat"},     32'(sat),     32'(exp_sat));
    chk({tag, ".upd_cnt"}, 32'(upd_cnt), 32'(exp_cnt));
  endtask

  task automatic tick(input bit v, input int s, input int a, input int r,
                      input int qc, input int qm, input bit fl);
    int k;
    int j;
    int q;
    bit sb;
    @(negedge clk);
    in_valid = v;
    state    = 6'(s);
    action   = 2'(a);
    reward   = 16'(r);
    q_cur    = 16'(qc);
    q_max    = 16'(qm);
    flush    = fl;
    @(posedge clk);
    k = cyc;
    cyc++;
    hv[k] = v; hf[k] = fl; hw[k] = 1'b0; ha[k] = {2'(s), 2'(a)} | (8'(s) << 2);
    ha[k] = 8'((s << 2) | a);
    hr[k] = r; hqc[k] = qc; hqm[k] = qm;
    #1;
    exp_we = 1'b0;
    j = k - 2;
    if (j >= base && hv[j] && !hf[j] && !hf[j+1] && !hf[k]) begin
      q = hqc[j];
      if (j - 1 >= base && hw[j-1] && ha[j-1] == ha[j])      q = hres[j-1];
      else if (j - 2 >= base && hw[j-2] && ha[j-2] == ha[j]) q = hres[j-2];
      hres[j]  = upd(hr[j], hqm[j], q, sb);
      hw[j]    = 1'b1;
      exp_we   = 1'b1;
      exp_addr = ha[j];
      exp_data = 16'(hres[j]);
      exp_sat  = sb;
      exp_cnt  = exp_cnt + 16'd1;
    end
    check_outputs("step");
  endtask

  task automatic idle();
    tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic model_reset();
    base     = cyc;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_sat  = 1'b0;
    exp_cnt  = '0;
  endtask

  logic [15:0] cnt0;
  logic [15:0] ovf_data;
  logic        ovf_sat;

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    state = '0; action = '0; reward = '0; q_cur = '0; q_max = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_outputs("reset0");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();

    // Basic update
    tick(1'b1, 5, 1, 100, 40, 80, 1'b0);
    idle();
    idle();
    chk("basic.wr_en", 32'(wr_en), 32'd1);
    chk("basic.addr",  32'(wr_addr), 32'h15);
    chk("basic.data",  32'(wr_data), 32'd72);
    chk("basic.cnt",   32'(upd_cnt), 32'd1);
    repeat (3) idle();

    // Back-to-back hazard: S2 forwarding
    tick(1'b1, 5, 1, 100, 40, 80, 1'b0);
    tick(1'b1, 5, 1, 100, 40, 80, 1'b0);
    idle();
    chk("b2b.first", 32'(wr_data), 32'd72);
    idle();
    chk("b2b.second", 32'(wr_data), 32'd96);
    repeat (3) idle();

    // One-cycle gap: write-stage forwarding
    tick(1'b1, 5, 1, 100, 40, 80, 1'b0);
    idle();
    tick(1'b1, 5, 1, 100, 40, 80, 1'b0);
    idle();
    idle();
    chk("gap.second", 32'(wr_data), 32'd96);
    repeat (3) idle();

    // Negative values and floor rounding
    tick(1'b1, 7, 2, -200, 0, 0, 1'b0);
    tick(1'b1, 9, 3, -1, 0, 0, 1'b0);
    idle();
    chk("neg.m50", 32'(wr_data), 32'h0000FFCE);
    idle();
    chk("neg.floor", 32'(wr_data), 32'h0000FFFF);
    repeat (3) idle();

    // Overflow
`ifdef QUPD_SAT_EN
    ovf_data = 16'h7FFF; ovf_sat = 1'b1;
`else
    ovf_data = 16'h9BFF; ovf_sat = 1'b0;
`endif
    tick(1'b1, 3, 0, 32767, 32767, 32767, 1'b0);
    idle();
    idle();
    chk("ovf.data", 32'(wr_data), 32'(ovf_data));
    chk("ovf.sat",  32'(sat),     32'(ovf_sat));
    repeat (3) idle();

    // Flush on the middle of three bundles
    cnt0 = upd_cnt + 16'd1;
    tick(1'b1, 5, 1, 100, 40, 80, 1'b0);
    tick(1'b1, 5, 1, 100, 40, 80, 1'b1);
    tick(1'b1, 5, 1, 100, 40, 80, 1'b0);
    repeat (4) idle();
    chk("flush.cnt",  32'(upd_cnt), 32'(cnt0));
    chk("flush.data", 32'(wr_data), 32'd72);

    // Asynchronous reset with valids in flight
    tick(1'b1, 1, 1, 500, 10, 20, 1'b0);
    tick(1'b1, 2, 2, 600, 30, 40, 1'b0);
    tick(1'b1, 3, 3, 700, 50, 60, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs("reset_mid");
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    repeat (4) idle();

    // Randomized traffic over a small address set to exercise forwarding
    for (int n = 0; n < 600; n++) begin
      tick(($urandom_range(0, 9) < 8), $urandom_range(0, 1), $urandom_range(0, 1),
           int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768,
           ($urandom_range(0, 19) == 0));
    end
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
